// File: rtl/y_histogram.sv
// y_histogram: per-frame luma histogram with a valid/ready drain port.
// Pixels are binned by the top BINBITS bits of y_i while accumulating; after
// LINES line_end pulses every bin is presented once, in order, and cleared on
// acceptance, followed by a single frame_done_o cycle.
// Optional build macro Y_HIST_SATURATE_EN: bins saturate instead of wrapping
// and a sticky sat_o output reports blocked increments (cleared at frame end).
module y_histogram #(
    parameter int COLORDEPTH = 8,
    parameter int BINBITS    = 4,
    parameter int CNTWIDTH   = 20,
    parameter int LINES      = 720
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COLORDEPTH-1:0] y_i,
    input  logic                  dv_i,
    input  logic                  line_end,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [BINBITS-1:0]    rd_bin_o,
    output logic [CNTWIDTH-1:0]   rd_count_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  drop_o
`ifdef Y_HIST_SATURATE_EN
    ,
    output logic                  sat_o
`endif
);

    localparam int NBINS = 1 << BINBITS;
    localparam int LCW   = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [LCW-1:0]     LINE_LAST = LCW'(LINES - 1);
    localparam logic [BINBITS-1:0] BIN_LAST  = BINBITS'(NBINS - 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [LCW-1:0]      r_line_cnt;
    logic [BINBITS-1:0]  r_rd_bin;
    logic [CNTWIDTH-1:0] r_bins [NBINS];
    logic                r_drop;

    logic [BINBITS-1:0]  w_bin_idx;
    logic                w_accum;
    logic                w_pix;
    logic                w_last_line;
    logic                w_accept;
    logic                w_inc_blocked;
    logic                w_unused_lsbs;

    assign w_bin_idx   = y_i[COLORDEPTH-1 -: BINBITS];
    assign w_accum     = (r_state == ST_ACCUM);
    assign w_pix       = w_accum && dv_i;
    assign w_last_line = w_accum && line_end && (r_line_cnt == LINE_LAST);
    assign w_accept    = (r_state == ST_DRAIN) && rd_ready_i;

    // Only the luma MSBs select a bin; the remaining bits are intentionally ignored.
    assign w_unused_lsbs = &{1'b0, y_i};

`ifdef Y_HIST_SATURATE_EN
    logic r_sat;
    logic w_bin_full;

    assign w_bin_full    = (r_bins[w_bin_idx] == {CNTWIDTH{1'b1}});
    assign w_inc_blocked = w_bin_full;
    assign sat_o         = r_sat;

    // Sticky saturation flag, re-armed by the frame_done_o cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_sat <= 1'b0;
        end else if (w_pix && w_bin_full) begin
            r_sat <= 1'b1;
        end
    end
`else
    assign w_inc_blocked = 1'b0;
`endif

    // Frame sequencing: ACCUM -> DRAIN after the last line, DRAIN -> DONE after the last bin.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_last_line) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_accept && (r_rd_bin == BIN_LAST)) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_ACCUM;
                default:  r_state <= ST_ACCUM;
            endcase
        end
    end

    // Line counter; line_end is only honoured while accumulating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_cnt <= '0;
        end else if (w_accum && line_end) begin
            r_line_cnt <= w_last_line ? '0 : r_line_cnt + 1'b1;
        end
    end

    // Drain read pointer; naturally wraps to 0 after the last bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bin <= '0;
        end else if (w_accept) begin
            r_rd_bin <= r_rd_bin + 1'b1;
        end
    end

    // Bin storage: increment on accepted pixels, clear each bin as it is read out.
    // NOTE: the bins are flops with an explicit reset because a reset must discard a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (w_accept) begin
            r_bins[r_rd_bin] <= '0;
        end else if (w_pix && !w_inc_blocked) begin
            r_bins[w_bin_idx] <= r_bins[w_bin_idx] + 1'b1;
        end
    end

    // Sticky drop flag for pixels arriving while the histogram is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (!w_accum && dv_i) begin
            r_drop <= 1'b1;
        end
    end

    assign rd_valid_o   = (r_state == ST_DRAIN);
    assign rd_bin_o     = r_rd_bin;
    assign rd_count_o   = rd_valid_o ? r_bins[r_rd_bin] : '0;
    assign frame_done_o = (r_state == ST_DONE);
    assign busy_o       = !w_accum;
    assign drop_o       = r_drop;

endmodule
